// File: rtl/id_stage_hzd.sv
// MIPS ID stage: opcode decode, GPR file with write-through bypass, immediate extension,
// load-use stall detection and bubble insertion into the ID/EX register.
module id_stage_hzd #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           if_id_instr,
    input  logic [DATA_W-1:0]     if_id_npc,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_writereg,
    input  logic [DATA_W-1:0]     wb_writedata,
    input  logic                  ex_memread,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  flush,
    output logic                  stall,
    output logic [1:0]            wb,
    output logic [2:0]            m,
    output logic [3:0]            ex,
    output logic [DATA_W-1:0]     npc,
    output logic [DATA_W-1:0]     rdata1,
    output logic [DATA_W-1:0]     rdata2,
    output logic [DATA_W-1:0]     imm,
    output logic [REG_ADDR_W-1:0] rt_out,
    output logic [REG_ADDR_W-1:0] rd_out
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    logic [DATA_W-1:0]     gpr_q [NUM_REGS];
    logic [DATA_W-1:0]     gpr_d [NUM_REGS];

    logic [1:0]            wb_q, wb_d;
    logic [2:0]            m_q, m_d;
    logic [3:0]            ex_q, ex_d;
    logic [DATA_W-1:0]     npc_q, npc_d;
    logic [DATA_W-1:0]     rdata1_q, rdata1_d;
    logic [DATA_W-1:0]     rdata2_q, rdata2_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [REG_ADDR_W-1:0] rt_q, rt_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [IMM_W-1:0]      imm_raw;
    logic [1:0]            dec_wb;
    logic [2:0]            dec_m;
    logic [3:0]            dec_ex;
    logic                  uses_rt;
    logic                  zero_ext;
    logic                  bubble;
    logic [DATA_W-1:0]     rd1_val;
    logic [DATA_W-1:0]     rd2_val;

    assign opcode  = if_id_instr[31:26];
    assign rs_addr = if_id_instr[21 +: REG_ADDR_W];
    assign rt_addr = if_id_instr[16 +: REG_ADDR_W];
    assign rd_addr = if_id_instr[11 +: REG_ADDR_W];
    assign imm_raw = if_id_instr[IMM_W-1:0];

    always_comb begin
        dec_wb   = 2'b00;
        dec_m    = 3'b000;
        dec_ex   = 4'b0000;
        uses_rt  = 1'b0;
        zero_ext = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin dec_wb = 2'b10; dec_ex = 4'b1100; uses_rt = 1'b1; end
            OP_LW:    begin dec_wb = 2'b11; dec_m = 3'b010; dec_ex = 4'b0001; end
            OP_SW:    begin dec_m = 3'b001; dec_ex = 4'b0001; uses_rt = 1'b1; end
            OP_BEQ:   begin dec_m = 3'b100; dec_ex = 4'b0010; uses_rt = 1'b1; end
            OP_ADDI:  begin dec_wb = 2'b10; dec_ex = 4'b0001; end
            OP_ANDI,
            OP_ORI:   begin dec_wb = 2'b10; dec_ex = 4'b0111; zero_ext = 1'b1; end
            default:  ;
        endcase
    end

    // Write-through: a same-cycle WB write to the addressed register wins over the stored value.
    always_comb begin
        rd1_val = gpr_q[rs_addr];
        rd2_val = gpr_q[rt_addr];
        if (wb_regwrite && (wb_writereg == rs_addr)) rd1_val = wb_writedata;
        if (wb_regwrite && (wb_writereg == rt_addr)) rd2_val = wb_writedata;
        if (rs_addr == '0) rd1_val = '0;
        if (rt_addr == '0) rd2_val = '0;
    end

    assign stall  = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == rs_addr) || ((ex_rt == rt_addr) && uses_rt));
    assign bubble = stall || flush;

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) gpr_d[i] = gpr_q[i];
        if (wb_regwrite && (wb_writereg != '0)) gpr_d[wb_writereg] = wb_writedata;

        wb_d     = bubble ? 2'b00   : dec_wb;
        m_d      = bubble ? 3'b000  : dec_m;
        ex_d     = bubble ? 4'b0000 : dec_ex;
        npc_d    = if_id_npc;
        rdata1_d = rd1_val;
        rdata2_d = rd2_val;
        imm_d    = zero_ext ? DATA_W'(imm_raw) : DATA_W'($signed(imm_raw));
        rt_d     = rt_addr;
        rd_d     = rd_addr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= '0;
            wb_q     <= '0;
            m_q      <= '0;
            ex_q     <= '0;
            npc_q    <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) gpr_q[i] <= gpr_d[i];
            wb_q     <= wb_d;
            m_q      <= m_d;
            ex_q     <= ex_d;
            npc_q    <= npc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
        end
    end

    assign wb     = wb_q;
    assign m      = m_q;
    assign ex     = ex_q;
    assign npc    = npc_q;
    assign rdata1 = rdata1_q;
    assign rdata2 = rdata2_q;
    assign imm    = imm_q;
    assign rt_out = rt_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_id_stage_hzd.sv
// Directed bench for id_stage_hzd: decode, bypass, extension, load-use stall, flush and reset.
module tb_id_stage_hzd;

    logic        clk;
    logic        rst;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_npc;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_writedata;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        flush;
    logic        stall;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [4:0]  rt_out;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    id_stage_hzd #(.DATA_W(32), .REG_ADDR_W(5), .IMM_W(16)) dut (
        .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_writedata(wb_writedata),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .flush(flush), .stall(stall),
        .wb(wb), .m(m), .ex(ex), .npc(npc), .rdata1(rdata1), .rdata2(rdata2),
        .imm(imm), .rt_out(rt_out), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic [1:0] e_wb, input logic [2:0] e_m,
                              input logic [3:0] e_ex);
        check({tag, ".wb"}, 64'(wb), 64'(e_wb));
        check({tag, ".m"},  64'(m),  64'(e_m));
        check({tag, ".ex"}, 64'(ex), 64'(e_ex));
    endtask

    task automatic check_all_zero(input string tag);
        check_ctrl(tag, 2'b00, 3'b000, 4'b0000);
        check({tag, ".npc"},  64'(npc),    64'd0);
        check({tag, ".rd1"},  64'(rdata1), 64'd0);
        check({tag, ".rd2"},  64'(rdata2), 64'd0);
        check({tag, ".imm"},  64'(imm),    64'd0);
        check({tag, ".rt"},   64'(rt_out), 64'd0);
        check({tag, ".rd"},   64'(rd_out), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        if_id_instr = 32'h0; if_id_npc = 32'h0;
        wb_regwrite = 1'b0; wb_writereg = 5'd0; wb_writedata = 32'h0;
        ex_memread = 1'b0; ex_rt = 5'd0; flush = 1'b0;
        #2;
        check_all_zero("reset_init");
        #10;
        rst = 1'b0;

        // bypass: write r5 while add $3,$5,$0 sits in ID
        if_id_instr = 32'h00A01820; if_id_npc = 32'h0000_0104;
        wb_regwrite = 1'b1; wb_writereg = 5'd5; wb_writedata = 32'hDEADBEEF;
        step();
        check("bypass.rd1", 64'(rdata1), 64'hDEADBEEF);
        check("bypass.rd2", 64'(rdata2), 64'd0);
        check_ctrl("bypass", 2'b10, 3'b000, 4'b1100);
        check("bypass.npc", 64'(npc), 64'h104);
        check("bypass.rd",  64'(rd_out), 64'd3);

        // r5 now stored in the file
        wb_regwrite = 1'b0;
        if_id_instr = 32'h00A51820;
        step();
        check("stored.rd1", 64'(rdata1), 64'hDEADBEEF);
        check("stored.rd2", 64'(rdata2), 64'hDEADBEEF);
        check("stored.rt",  64'(rt_out), 64'd5);

        // immediate extension
        if_id_instr = 32'h20018000;
        step();
        check("addi.imm", 64'(imm), 64'hFFFF8000);
        check_ctrl("addi", 2'b10, 3'b000, 4'b0001);
        if_id_instr = 32'h34018000;
        step();
        check("ori.imm", 64'(imm), 64'h00008000);
        check_ctrl("ori", 2'b10, 3'b000, 4'b0111);
        if_id_instr = 32'h30018000;
        step();
        check("andi.imm", 64'(imm), 64'h00008000);
        check_ctrl("andi", 2'b10, 3'b000, 4'b0111);

        // memory and branch decodes
        if_id_instr = 32'h8C020004;
        step();
        check_ctrl("lw", 2'b11, 3'b010, 4'b0001);
        check("lw.rt", 64'(rt_out), 64'd2);
        if_id_instr = 32'hAC020004;
        step();
        check_ctrl("sw", 2'b00, 3'b001, 4'b0001);
        if_id_instr = 32'h1000FFFF;
        step();
        check_ctrl("beq", 2'b00, 3'b100, 4'b0010);
        check("beq.imm", 64'(imm), 64'hFFFFFFFF);

        // load-use hazards
        ex_memread = 1'b1; ex_rt = 5'd7;
        if_id_instr = 32'h00E01820;
        #1;
        check("lu_rs.stall", 64'(stall), 64'd1);
        step();
        check_ctrl("lu_rs.bubble", 2'b00, 3'b000, 4'b0000);
        if_id_instr = 32'h00071820;
        #1;
        check("lu_rt_r.stall", 64'(stall), 64'd1);
        if_id_instr = 32'hAC070000;
        #1;
        check("lu_rt_sw.stall", 64'(stall), 64'd1);
        if_id_instr = 32'h20470005;
        #1;
        check("lu_addi.stall", 64'(stall), 64'd0);
        step();
        check_ctrl("lu_addi", 2'b10, 3'b000, 4'b0001);
        check("lu_addi.imm", 64'(imm), 64'd5);
        if_id_instr = 32'h8C070000;
        #1;
        check("lu_lw_rt.stall", 64'(stall), 64'd0);
        ex_memread = 1'b0;
        if_id_instr = 32'h00E01820;
        #1;
        check("no_memread.stall", 64'(stall), 64'd0);

        // r0: never written, never stalls
        ex_memread = 1'b1; ex_rt = 5'd0;
        wb_regwrite = 1'b1; wb_writereg = 5'd0; wb_writedata = 32'h1234;
        if_id_instr = 32'h00000020;
        #1;
        check("r0.stall", 64'(stall), 64'd0);
        step();
        check("r0.bypass", 64'(rdata1), 64'd0);
        wb_regwrite = 1'b0; ex_memread = 1'b0;
        step();
        check("r0.read1", 64'(rdata1), 64'd0);
        check("r0.read2", 64'(rdata2), 64'd0);

        // flush and unknown opcode
        flush = 1'b1;
        if_id_instr = 32'h8C020004;
        step();
        check_ctrl("flush_lw", 2'b00, 3'b000, 4'b0000);
        flush = 1'b0;
        if_id_instr = 32'hFC000000;
        step();
        check_ctrl("unknown_op", 2'b00, 3'b000, 4'b0000);

        // flush with stall: stall remains visible
        flush = 1'b1; ex_memread = 1'b1; ex_rt = 5'd7;
        if_id_instr = 32'h00E01820;
        #1;
        check("flush_stall.stall", 64'(stall), 64'd1);
        step();
        check_ctrl("flush_stall", 2'b00, 3'b000, 4'b0000);
        flush = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0;

        // mid-run async reset, then GPRs read back zero
        if_id_instr = 32'h8CA20004; if_id_npc = 32'h0000_0200;
        step();
        check_ctrl("pre_rst", 2'b11, 3'b010, 4'b0001);
        check("pre_rst.rd1", 64'(rdata1), 64'hDEADBEEF);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #1;
        rst = 1'b0;
        if_id_instr = 32'h00A51820;
        step();
        check("post_rst.rd1", 64'(rdata1), 64'd0);
        check("post_rst.rd2", 64'(rdata2), 64'd0);
        check_ctrl("post_rst", 2'b10, 3'b000, 4'b1100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
